mux_rr_arbiter: RTL

Round-robin arbiter that shares the 4:1 4-bit multiplexer between four requesters. It turns a 4-bit request vector into a registered one-hot grant and a 2-bit select that drives the multiplexer's select input. Ownership is held across multi-cycle bursts and handed over with no idle cycle. It sits directly in front of the shared mux, and the mux data path is unchanged.

---
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of the shared 4:1 4-bit mux: registered one-hot grant plus select.
// Define MUX_ARB_BURST_LIMIT_EN to compile in the MAX_BURST forced-rotation counter.
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t      state, next_state;
    logic [3:0]  next_grant;
    logic [1:0]  next_select;
    logic [1:0]  last, next_last;
    logic [2:0]  pick;

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
    logic [CW-1:0] cnt, next_cnt;
`else
    localparam int unused_max_burst = MAX_BURST;
`endif

    // Returns {found, index}: first set bit of r scanning base+1, base+2, base+3, base.
    // Scanning from the farthest offset down lets the nearest hit overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        next_state  = state;
        next_grant  = grant;
        next_select = select;
        next_last   = last;
        pick        = 3'b000;
`ifdef MUX_ARB_BURST_LIMIT_EN
        next_cnt    = cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) pick = rr_pick(req, last);
            end
            OWN: begin
                if (!req[select]) begin
                    pick = rr_pick(req & ~(4'b0001 << select), select);
                    if (!pick[2]) begin
                        next_state = IDLE;
                        next_grant = 4'b0000;
                    end
`ifdef MUX_ARB_BURST_LIMIT_EN
                end else if (cnt == CNT_MAX) begin
                    // Owner is searched last, so it only wins again when alone.
                    pick = rr_pick(req, select);
                end else begin
                    next_cnt = cnt + CW'(1);
`endif
                end
            end
            default: begin
                next_state = IDLE;
                next_grant = 4'b0000;
            end
        endcase

        // Any successful search is a new grant, including a burst-limit re-grant.
        if (pick[2]) begin
            next_state  = OWN;
            next_grant  = 4'b0001 << pick[1:0];
            next_select = pick[1:0];
            next_last   = pick[1:0];
`ifdef MUX_ARB_BURST_LIMIT_EN
            next_cnt    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= 4'b0000;
            select <= 2'd0;
            last   <= 2'd3;
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt    <= '0;
`endif
        end else begin
            state  <= next_state;
            grant  <= next_grant;
            select <= next_select;
            last   <= next_last;
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt    <= next_cnt;
`endif
        end
    end

    assign busy = |grant;

endmodule
